// File: rtl/karatsuba_pp_gen_16bit.sv
// Karatsuba partial-product generator for one GF(2) 16x16 level: lo, hi and mid
// products computed in turn on one shared bit-serial carry-less multiplier.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for an operand pair (in_ready high)
// S_MUL_LO  | accumulating clmul(aL, bL), one bit of bL per cycle
// S_MUL_HI  | accumulating clmul(aH, bH)
// S_MUL_MID | accumulating clmul(aL^aH, bL^bH), folded with lo and hi
// S_DONE    | partial products valid, held until out_ready
module karatsuba_pp_gen_16bit #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a_in,
  input  logic [n-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-2:0] pp_lo,
  output logic [n-2:0] pp_mid,
  output logic [n-2:0] pp_hi
);

  localparam int H  = n / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL_LO  = 3'd1,
    S_MUL_HI  = 3'd2,
    S_MUL_MID = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [n-1:0]   r_a;
  logic [n-1:0]   r_b;
  logic [n-2:0]   r_acc;
  logic [CW-1:0]  r_cnt;
  logic [n-2:0]   r_pp_lo;
  logic [n-2:0]   r_pp_mid;
  logic [n-2:0]   r_pp_hi;

  logic [H-1:0]   w_x;
  logic [H-1:0]   w_y;
  logic [n-2:0]   w_x_ext;
  logic [n-2:0]   w_term;
  logic [n-2:0]   w_acc_next;
  logic           w_last;

  // Operand selection for the shared multiplier, driven by the current phase.
  always_comb begin
    w_x = r_a[H-1:0];
    w_y = r_b[H-1:0];
    case (r_state)
      S_MUL_HI: begin
        w_x = r_a[n-1:H];
        w_y = r_b[n-1:H];
      end
      S_MUL_MID: begin
        w_x = r_a[H-1:0] ^ r_a[n-1:H];
        w_y = r_b[H-1:0] ^ r_b[n-1:H];
      end
      default: ;
    endcase
  end

  assign w_x_ext    = {{(n-1-H){1'b0}}, w_x};
  assign w_term     = w_y[r_cnt] ? (w_x_ext << r_cnt) : '0;
  assign w_acc_next = r_acc ^ w_term;
  assign w_last     = (r_cnt == CW'(H-1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (in_valid)  w_state_next = S_MUL_LO;
      S_MUL_LO:  if (w_last)    w_state_next = S_MUL_HI;
      S_MUL_HI:  if (w_last)    w_state_next = S_MUL_MID;
      S_MUL_MID: if (w_last)    w_state_next = S_DONE;
      S_DONE:    if (out_ready) w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_pp_lo  <= '0;
      r_pp_mid <= '0;
      r_pp_hi  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_MUL_LO, S_MUL_HI, S_MUL_MID: begin
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
            // mid folds in lo and hi so the overlap stage needs no extra XORs
            if (r_state == S_MUL_LO)      r_pp_lo  <= w_acc_next;
            else if (r_state == S_MUL_HI) r_pp_hi  <= w_acc_next;
            else                          r_pp_mid <= w_acc_next ^ r_pp_lo ^ r_pp_hi;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign pp_lo     = r_pp_lo;
  assign pp_mid    = r_pp_mid;
  assign pp_hi     = r_pp_hi;

endmodule

// File: tb/tb_karatsuba_pp_gen_16bit.sv
// Directed bench for karatsuba_pp_gen_16bit: latency, handshake, backpressure,
// mid-operation reset and a short random sweep against a plain carry-less multiply.
module tb_karatsuba_pp_gen_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] pp_lo;
  logic [14:0] pp_mid;
  logic [14:0] pp_hi;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  karatsuba_pp_gen_16bit #(.n(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_lo     (pp_lo),
    .pp_mid    (pp_mid),
    .pp_hi     (pp_hi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] clmul16(input logic [15:0] a, input logic [15:0] b);
    logic [30:0] r = '0;
    for (int i = 0; i < 16; i++)
      if (b[i]) r = r ^ (31'(a) << i);
    return r;
  endfunction

  function automatic logic [14:0] clmul8(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) r = r ^ (15'(a) << i);
    return r;
  endfunction

  function automatic logic [30:0] overlap(input logic [14:0] lo, input logic [14:0] mid,
                                          input logic [14:0] hi);
    return 31'(lo) ^ (31'(mid) << 8) ^ (31'(hi) << 16);
  endfunction

  // in_ready and out_valid must never coincide
  always @(negedge clk)
    if (!rst) check("rdy_vld_excl", 32'(in_ready & out_valid), 32'd0);

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_pp_lo"},     32'(pp_lo),     32'd0);
    check({tag, "_pp_mid"},    32'(pp_mid),    32'd0);
    check({tag, "_pp_hi"},     32'(pp_hi),     32'd0);
  endtask

  // Runs one operation; stalls 'stall' cycles in DONE while poking the inputs.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stall,
                        output logic [14:0] lo, output logic [14:0] mid, output logic [14:0] hi);
    int lat;
    @(negedge clk);
    check("accept_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in     = 16'($urandom);
    b_in     = 16'($urandom);
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", 32'(lat), 32'd25);
    lo  = pp_lo;
    mid = pp_mid;
    hi  = pp_hi;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      a_in     = 16'($urandom);
      b_in     = 16'($urandom);
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_pp", {2'b0, pp_lo ^ lo, pp_mid ^ mid}, 32'd0);
      check("stall_pp_hi", 32'(pp_hi), 32'(hi));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_in_ready",  32'(in_ready),  32'd1);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [14:0] lo;
    logic [14:0] mid;
    logic [14:0] hi;
    logic [31:0] prod;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [14:0] lo, mid, hi;
    int seen;

    vecs[0] = '{16'h0001, 16'h0001, 15'h0001, 15'h0000, 15'h0000, 32'h0000_0001};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 15'h5555, 15'h0000, 15'h5555, 32'h5555_5555};
    vecs[2] = '{16'h0101, 16'h0003, 15'h0003, 15'h0003, 15'h0000, 32'h0000_0303};
    vecs[3] = '{16'h0100, 16'h0100, 15'h0000, 15'h0000, 15'h0001, 32'h0001_0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 0, lo, mid, hi);
      check($sformatf("v%0d_pp_lo", i),  32'(lo),  32'(vecs[i].lo));
      check($sformatf("v%0d_pp_mid", i), 32'(mid), 32'(vecs[i].mid));
      check($sformatf("v%0d_pp_hi", i),  32'(hi),  32'(vecs[i].hi));
      check($sformatf("v%0d_prod", i),   32'(overlap(lo, mid, hi)), vecs[i].prod);
    end

    // backpressure: 10 stalled cycles with input noise, then release
    run_op(16'h0101, 16'h0003, 10, lo, mid, hi);
    check("bp_prod", 32'(overlap(lo, mid, hi)), 32'h0000_0303);

    // reset at cycle 12 of an operation, after pp_lo has already been written
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 16'hFFFF;
    b_in     = 16'hFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_rst_pp_lo", 32'(pp_lo), 32'h5555);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_valid_after_rst", 32'(seen), 32'd0);

    run_op(16'h1234, 16'h5678, 0, lo, mid, hi);
    check("post_rst_prod", 32'(overlap(lo, mid, hi)), 32'(clmul16(16'h1234, 16'h5678)));
    check("post_rst_lo", 32'(lo), 32'(clmul8(8'h34, 8'h78)));
    check("post_rst_hi", 32'(hi), 32'(clmul8(8'h12, 8'h56)));

    for (int k = 0; k < 200; k++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(a, b, $urandom_range(0, 3), lo, mid, hi);
      check("rand_prod", 32'(overlap(lo, mid, hi)), 32'(clmul16(a, b)));
      check("rand_mid", 32'(mid),
            32'(clmul8(a[7:0] ^ a[15:8], b[7:0] ^ b[15:8]) ^ lo ^ hi));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
